// File: rtl/scan_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : scan_sequencer                                                |
// | Sweeps a 4-to-16 decoder select 0..15, holding each channel DWELL cycles.|
// | Option   : define SCAN_GAP_EN for one enable-low cycle per channel change.|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module scan_sequencer #(
   parameter int DWELL = 4
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Start,
   input  logic       Stop,
   input  logic       Mode,
   output logic       En,
   output logic [3:0] W,
   output logic       Busy,
   output logic       Done
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
`ifdef SCAN_GAP_EN
   localparam logic [1:0] ST_GAP    = 2'd2;
`endif
   localparam logic [1:0] ST_DONE   = 2'd3;
   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

   logic [1:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] w_q, w_d;
   logic       mode_q, mode_d;
   logic       en_q, en_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         w_q     <= 4'd0;
         mode_q  <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         w_q     <= w_d;
         mode_q  <= mode_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      w_d     = w_q;
      mode_d  = mode_q;
      case (state_q)
         ST_IDLE: begin
            w_d   = 4'd0;
            cnt_d = 8'd0;
            if (Start && !Stop) begin
               mode_d  = Mode;
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (cnt_q == DWELL_LAST) begin
               cnt_d = 8'd0;
               if (w_q != 4'd15) begin
                  w_d = w_q + 4'd1;
`ifdef SCAN_GAP_EN
                  state_d = ST_GAP;
`endif
               end else if (mode_q) begin
                  w_d = 4'd0;
`ifdef SCAN_GAP_EN
                  state_d = ST_GAP;
`endif
               end else begin
                  w_d     = 4'd0;
                  state_d = ST_DONE;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
`ifdef SCAN_GAP_EN
         // W already holds the next channel here; only the enable is low.
         ST_GAP: begin
            state_d = ST_ACTIVE;
         end
`endif
         ST_DONE: begin
            w_d     = 4'd0;
            state_d = ST_IDLE;
         end
         default: begin
            w_d     = 4'd0;
            cnt_d   = 8'd0;
            state_d = ST_IDLE;
         end
      endcase
      // Abort outranks dwell expiry and the done pulse.
      if (Stop) begin
         state_d = ST_IDLE;
         w_d     = 4'd0;
         cnt_d   = 8'd0;
      end
   end

   always_comb begin
      en_d   = (state_d == ST_ACTIVE);
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   assign En   = en_q;
   assign W    = w_q;
   assign Busy = busy_q;
   assign Done = done_q;

endmodule
`default_nettype wire
